byte_frame_assembler: RTL and testbench



---
 rtl/byte_frame_assembler.sv | 188 ++++++++++++++++++
 tb/tb_byte_frame_assembler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_frame_assembler.sv
// Length-prefixed frame parser: FIFO-buffered bytes in, payload out with last flag, pass/fail pulses.
// Define FRAME_STATS_EN to add saturating good/bad frame counters with a synchronous clear.
module byte_frame_assembler #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LEN    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [7:0]                    out_data,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic                          frame_ok,
    output logic                          frame_err,
    output logic [1:0]                    err_code,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FRAME_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [15:0]                   good_cnt,
    output logic [15:0]                   bad_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0] LP_MAX = 8'(MAX_LEN);

    typedef enum logic [1:0] {S_LEN, S_PAY, S_CHK} state_t;

    state_t         r_state, w_state_nxt;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]  r_count;
    logic [7:0]     r_sum, r_remaining;
    logic           r_out_valid, r_out_last, r_frame_ok, r_frame_err;
    logic [7:0]     r_out_data;
    logic [1:0]     r_err_code;

    logic           w_full, w_empty, w_push, w_pop, w_out_free;
    logic           w_load, w_len_bad, w_len_ok, w_chk;
    logic [7:0]     w_head;

    assign w_full     = (r_count == LW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    // Held low during reset so upstream never pushes into a FIFO being flushed.
    assign in_ready   = !rst && !w_full;
    assign w_push     = in_valid && in_ready;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LEN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_len_bad   = 1'b0;
        w_len_ok    = 1'b0;
        w_chk       = 1'b0;
        case (r_state)
            S_LEN: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head == 8'd0 || w_head > LP_MAX) begin
                        w_len_bad = 1'b1;
                    end else begin
                        w_len_ok    = 1'b1;
                        w_state_nxt = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (!w_empty && w_out_free) begin
                    w_pop  = 1'b1;
                    w_load = 1'b1;
                    if (r_remaining == 8'd1) w_state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                // The checksum does not wait for the last payload byte to drain.
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_chk       = 1'b1;
                    w_state_nxt = S_LEN;
                end
            end
            default: w_state_nxt = S_LEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum       <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_len_bad || w_len_ok) r_sum <= '0;
            if (w_len_ok) r_remaining <= w_head;
            if (w_len_bad) begin
                r_frame_err <= 1'b1;
                r_err_code  <= 2'd1;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head;
                r_out_last  <= (r_remaining == 8'd1);
                r_sum       <= r_sum + w_head;
                r_remaining <= r_remaining - 8'd1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_chk) begin
                if (w_head == r_sum) begin
                    r_frame_ok <= 1'b1;
                    r_err_code <= 2'd0;
                end else begin
                    r_frame_err <= 1'b1;
                    r_err_code  <= 2'd2;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign frame_ok   = r_frame_ok;
    assign frame_err  = r_frame_err;
    assign err_code   = r_err_code;
    assign busy       = (r_state != S_LEN);
    assign fifo_level = r_count;

`ifdef FRAME_STATS_EN
    logic [15:0] r_good_cnt, r_bad_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (stats_clr) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            if (r_frame_ok && r_good_cnt != 16'hFFFF)  r_good_cnt <= r_good_cnt + 16'd1;
            if (r_frame_err && r_bad_cnt != 16'hFFFF)  r_bad_cnt  <= r_bad_cnt + 16'd1;
        end
    end

    assign good_cnt = r_good_cnt;
    assign bad_cnt  = r_bad_cnt;
`endif

endmodule

// File: tb/tb_byte_frame_assembler.sv
// Scoreboard bench for byte_frame_assembler: a frame model fills expected byte/result queues,
// a negedge monitor pops them on every output handshake and every pass/fail pulse.
module tb_byte_frame_assembler;

    localparam int DEPTH   = 4;
    localparam int MAX_LEN = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_last, frame_ok, frame_err, busy;
    logic [7:0] out_data;
    logic [1:0] err_code;
    logic [$clog2(DEPTH):0] fifo_level;
`ifdef FRAME_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] good_cnt, bad_cnt;
`endif

    byte_frame_assembler #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
        .busy(busy), .fifo_level(fifo_level)
`ifdef FRAME_STATS_EN
        , .stats_clr(stats_clr), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] exp_q[$];   // {last, data}
    logic [3:0] res_q[$];   // {ok, err, code}
    logic [7:0] stim_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Monitor: outputs are stable at the falling edge; a handshake seen here completes on the next rise.
    logic       hold_pend = 1'b0;
    logic [8:0] hold_val  = 9'd0;
    always @(negedge clk) begin
        if (rst) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_last, out_data}, hold_val);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", {out_last, out_data}, 32'h1ff);
                else check("out_byte", {out_last, out_data}, exp_q.pop_front());
            end
            hold_pend <= out_valid && !out_ready;
            hold_val  <= {out_last, out_data};
            if (frame_ok || frame_err) begin
                if (res_q.size() == 0) check("unexpected_pulse", {frame_ok, frame_err, err_code}, 0);
                else check("pulse", {frame_ok, frame_err, err_code}, res_q.pop_front());
            end
        end
    end

    // Reference parser: turns the byte stream in stim_q into expected payload and result entries.
    task automatic model_frames();
        int idx = 0;
        while (idx < stim_q.size()) begin
            logic [7:0] len, sum, b;
            len = stim_q[idx]; idx++;
            if (len == 0 || len > MAX_LEN) begin
                res_q.push_back(4'b0101);
            end else begin
                sum = 8'd0;
                for (int i = 0; i < int'(len); i++) begin
                    b = stim_q[idx]; idx++;
                    sum = sum + b;
                    exp_q.push_back({(i == int'(len) - 1), b});
                end
                b = stim_q[idx]; idx++;
                res_q.push_back((b == sum) ? 4'b1000 : 4'b0110);
            end
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge that accepted the byte.
    task automatic drive_byte(input logic [7:0] b);
        int budget = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && budget < 500) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_all();
        for (int i = 0; i < stim_q.size(); i++) drive_byte(stim_q[i]);
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((exp_q.size() != 0 || res_q.size() != 0) && c < 1000) begin
            @(posedge clk);
            c++;
        end
        check("drain_timeout", (exp_q.size() == 0 && res_q.size() == 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_frames();
        model_frames();
        drive_all();
        stim_q.delete();
        wait_drain();
    endtask

    task automatic wait_full_then_release();
        int c = 0;
        while (fifo_level != DEPTH && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("full_level", fifo_level, DEPTH);
        check("full_in_ready", in_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_pulses", {frame_ok, frame_err}, 0);
        check("rst_err_code", err_code, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        stim_q = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
        run_frames();
        check("t1_err_code", err_code, 0);
        check("t1_busy", busy, 0);

        stim_q = '{8'h02, 8'hAA, 8'h55, 8'h00};
        run_frames();
        check("t2_err_code", err_code, 2);

        stim_q = '{8'h00, 8'h01, 8'h7F, 8'h7F};
        run_frames();
        check("t3_err_code", err_code, 0);

        out_ready = 1'b0;
        stim_q = '{8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        model_frames();
        fork
            drive_all();
            wait_full_then_release();
        join
        stim_q.delete();
        wait_drain();
        check("t4_err_code", err_code, 0);

        stim_q = '{8'h02, 8'hFF, 8'h02, 8'h01};
        run_frames();

        // Longest legal frame, with a random payload and correct checksum.
        begin
            logic [7:0] s, b;
            s = 8'd0;
            stim_q.push_back(8'(MAX_LEN));
            for (int i = 0; i < MAX_LEN; i++) begin
                b = 8'($urandom_range(0, 255));
                s = s + b;
                stim_q.push_back(b);
            end
            stim_q.push_back(s);
            stim_q.push_back(8'(MAX_LEN + 1));
        end
        run_frames();
        check("tmax_err_code", err_code, 1);

        out_ready = 1'b0;
        drive_byte(8'h05);
        drive_byte(8'h11);
        drive_byte(8'h22);
        repeat (4) @(posedge clk);
        #1;
        check("t6_held_valid", out_valid, 1);
        check("t6_held_data", out_data, 8'h11);
        check("t6_busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_level", fifo_level, 0);
        check("t6_in_ready", in_ready, 0);
        check("t6_busy_rst", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        stim_q = '{8'h01, 8'h33, 8'h33};
        run_frames();
        check("t6_err_code", err_code, 0);
`ifdef FRAME_STATS_EN
        check("t6_good_cnt", good_cnt, 1);
        check("t6_bad_cnt", bad_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
